// File: rtl/arb_rr16_if.sv
// Request/grant bundle between 16 requesters and the round-robin arbiter.
// The master side drives requests; the slave side (arbiter) drives the grant.
interface arb_rr16_if;
   logic [15:0] req;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   logic        grant_valid;

   modport master (
      output req,
      input  grant,
      input  grant_idx,
      input  grant_valid
   );

   modport slave (
      input  req,
      output grant,
      output grant_idx,
      output grant_valid
   );
endinterface

// File: rtl/arb_rr16.sv
// 16-way round-robin arbiter with registered one-hot grant, binary index and an
// optional hold limit that preempts a long-running grant when others wait.
module arb_rr16 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input logic       clk,
   input logic       rst,
   arb_rr16_if.slave bus
);

   localparam logic [7:0] HoldLim = 8'(MAX_HOLD);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e      state_q;
   logic [3:0]  ptr_q;
   logic [7:0]  hold_cnt_q;
   logic [15:0] grant_q;
   logic [3:0]  idx_q;
   logic        valid_q;

   logic [3:0]  cand;
   logic [3:0]  win_idx;
   logic        win_any;
   logic        rel;
   logic        take;

   // Scan from ptr upward with wrap; iterating k downward lets the lowest offset win.
   always_comb begin
      cand    = ptr_q;
      win_idx = ptr_q;
      win_any = |bus.req;
      for (int k = 15; k >= 0; k--) begin
         cand = ptr_q + 4'(k);
         if (bus.req[cand]) win_idx = cand;
      end
   end

   always_comb begin
      rel  = !bus.req[idx_q] || ((MAX_HOLD != 0) && (hold_cnt_q == HoldLim));
      take = win_any && ((state_q == StIdle) || rel);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         grant_q    <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
      end else if (take) begin
         // Covers both a fresh grant from idle and a direct handoff on release.
         state_q    <= StGrant;
         ptr_q      <= win_idx + 4'd1;
         hold_cnt_q <= 8'd1;
         grant_q    <= 16'(1) << win_idx;
         idx_q      <= win_idx;
         valid_q    <= 1'b1;
      end else if (state_q == StGrant) begin
         if (!rel) begin
            if (hold_cnt_q != 8'hFF) hold_cnt_q <= hold_cnt_q + 8'd1;
         end else begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
         end
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_arb_rr16.sv
// Scoreboard bench for arb_rr16: directed scenarios plus random traffic checked
// against a round-robin model that tracks owner, pointer and cycles held.
module tb_arb_rr16;

   localparam int unsigned MH = 4;

   typedef struct packed {
      logic [15:0] g;
      logic [3:0]  i;
      logic        v;
   } exp_t;

   logic clk;
   logic rst;
   arb_rr16_if bus ();

   arb_rr16 #(.MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int m_ptr   = 0;
   int m_owner = -1;
   int m_held  = 0;

   function automatic int pick(input logic [15:0] q, input int p);
      for (int k = 0; k < 16; k++) begin
         if (q[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_grant(input logic [15:0] q);
      int w;
      w       = pick(q, m_ptr);
      m_owner = w;
      m_held  = 1;
      m_ptr   = (w + 1) % 16;
   endtask

   task automatic model_update(input logic r, input logic [15:0] q);
      bit release_now;
      if (r) begin
         m_ptr   = 0;
         m_owner = -1;
         m_held  = 0;
      end else if (m_owner < 0) begin
         if (q != 16'h0) model_grant(q);
      end else begin
         release_now = !q[m_owner] || (MH != 0 && m_held == int'(MH));
         if (!release_now) m_held = (m_held < 255) ? m_held + 1 : 255;
         else if (q != 16'h0) model_grant(q);
         else m_owner = -1;
      end
   endtask

   task automatic step(input logic r, input logic [15:0] q);
      exp_t e;
      rst     = r;
      bus.req = q;
      @(posedge clk);
      model_update(r, q);
      e.v = (m_owner >= 0);
      e.i = e.v ? 4'(m_owner) : 4'h0;
      e.g = e.v ? (16'(1) << m_owner) : 16'h0;
      exp_q.push_back(e);
      #2;
   endtask

   // Monitor: compares DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.grant !== e.g) begin
            errors++;
            $display("FAIL grant @%0t: got %h want %h", $time, bus.grant, e.g);
         end
         checks++;
         if (bus.grant_idx !== e.i) begin
            errors++;
            $display("FAIL grant_idx @%0t: got %0d want %0d", $time, bus.grant_idx, e.i);
         end
         checks++;
         if (bus.grant_valid !== e.v) begin
            errors++;
            $display("FAIL grant_valid @%0t: got %b want %b", $time, bus.grant_valid, e.v);
         end
      end
   end

   logic [15:0] rnd_req;

   initial begin
      rst     = 1'b1;
      bus.req = 16'h0;

      // Reset with all requesting, then full contention
      repeat (2) step(1'b1, 16'hFFFF);
      repeat (16 * MH + 8) step(1'b0, 16'hFFFF);

      // Single requester, held 3 cycles then dropped
      step(1'b1, 16'h0);
      repeat (3) step(1'b0, 16'h0020);
      repeat (3) step(1'b0, 16'h0000);

      // Wrap-around from 15 to 0
      step(1'b1, 16'h0);
      repeat (2) step(1'b0, 16'h8000);
      step(1'b0, 16'h8001);
      repeat (3) step(1'b0, 16'h0001);
      step(1'b0, 16'h0000);

      // Sole requester across several preemption points
      repeat (20) step(1'b0, 16'h0008);
      step(1'b0, 16'h0000);

      // Reset mid-grant on index 9
      step(1'b1, 16'h0);
      repeat (3) step(1'b0, 16'h0200);
      step(1'b1, 16'h0201);
      repeat (12) step(1'b0, 16'h0201);

      // Random traffic with sticky requests and rare resets
      rnd_req = 16'($urandom);
      for (int n = 0; n < 400; n++) begin
         for (int b = 0; b < 16; b++) begin
            if ($urandom_range(7, 0) == 0) rnd_req[b] = ~rnd_req[b];
         end
         step(($urandom_range(63, 0) == 0), rnd_req);
      end
      step(1'b0, 16'h0);

      // Bounded drain of the scoreboard
      for (int t = 0; t < 5 && exp_q.size() != 0; t++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
